// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the board SRAM arbiter: FSM states, bus widths
// and the default read/write strobe lengths.
package sram_arb_pkg;

   localparam int SRAM_ADDR_W   = 18;
   localparam int SRAM_DATA_W   = 16;
   localparam int DEF_RD_CYCLES = 2;
   localparam int DEF_WR_CYCLES = 3;
   localparam int CNT_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD
   } arb_state_e;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/sram_pin_drv.sv
// SRAM pad stage: registers address and strobes, owns the DQ tristate
// driver and the read-data sample register.
module sram_pin_drv
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_next,
   input  logic              we_n_d,
   input  logic              oe_n_d,
   input  logic              dq_oe_d,
   input  logic [DATA_W-1:0] wdata,
   input  logic              sample_en,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              sram_ce_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n,
   output logic [DATA_W-1:0] rd_data,
   inout  wire  [DATA_W-1:0] sram_dq
);

   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0] dq_out_q, rd_data_q, rd_data_d;
   logic              we_n_q, oe_n_q, dq_oe_q, ce_n_q;

   always_comb begin
      sram_addr_d = addr_load ? addr_next : sram_addr_q;
      rd_data_d   = sample_en ? sram_dq : rd_data_q;
   end

   // Chip is permanently selected with both byte lanes enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_addr_q <= '0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         dq_oe_q     <= 1'b0;
         ce_n_q      <= 1'b0;
         dq_out_q    <= '0;
         rd_data_q   <= '0;
      end else begin
         sram_addr_q <= sram_addr_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
         dq_oe_q     <= dq_oe_d;
         ce_n_q      <= 1'b0;
         dq_out_q    <= wdata;
         rd_data_q   <= rd_data_d;
      end
   end

   assign sram_dq   = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
   assign sram_addr = sram_addr_q;
   assign sram_we_n = we_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_ce_n = ce_n_q;
   assign sram_ub_n = ce_n_q;
   assign sram_lb_n = ce_n_q;
   assign rd_data   = rd_data_q;

endmodule

// File: rtl/sram_arbiter.sv
// Board SRAM arbiter: VGA reads (high priority) and fill-engine writes share
// one 256K x 16 SRAM. Optional statistics outputs under SRAM_ARB_STATS_EN.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W    = SRAM_ADDR_W,
   parameter int DATA_W    = SRAM_DATA_W,
   parameter int RD_CYCLES = DEF_RD_CYCLES,
   parameter int WR_CYCLES = DEF_WR_CYCLES
)
(
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              busy,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_WE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_CE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [ADDR_W-1:0] wr_count,
   output logic [3:0]        rd_wait_max
`endif
);

   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic [ADDR_W-1:0] rd_pend_addr_q, rd_pend_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_ack_q, wr_ack_d;
   logic              busy_q, busy_d;
   logic              we_n_d, oe_n_d, dq_oe_d;
   logic              addr_load, sample_en, rd_start;
   logic [ADDR_W-1:0] addr_next;

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         rd_pend_q      <= 1'b0;
         rd_pend_addr_q <= '0;
         wr_data_q      <= '0;
         rd_valid_q     <= 1'b0;
         wr_ack_q       <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rd_pend_q      <= rd_pend_d;
         rd_pend_addr_q <= rd_pend_addr_d;
         wr_data_q      <= wr_data_d;
         rd_valid_q     <= rd_valid_d;
         wr_ack_q       <= wr_ack_d;
         busy_q         <= busy_d;
      end
   end

   // Pin-facing strobes are decoded from the next state so they line up with the state register.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rd_pend_d      = rd_pend_q;
      rd_pend_addr_d = rd_pend_addr_q;
      wr_data_d      = wr_data_q;
      rd_valid_d     = 1'b0;
      sample_en      = 1'b0;
      addr_load      = 1'b0;
      addr_next      = wr_addr;
      rd_start       = 1'b0;

      if (rd_req) begin
         rd_pend_d      = 1'b1;
         rd_pend_addr_d = rd_addr;
      end

      case (state_q)
         ST_IDLE: begin
            if (rd_pend_q || rd_req) begin
               state_d   = ST_READ;
               cnt_d     = '0;
               rd_pend_d = 1'b0;
               rd_start  = 1'b1;
               addr_load = 1'b1;
               addr_next = rd_req ? rd_addr : rd_pend_addr_q;
            end else if (wr_req) begin
               state_d   = ST_WR_SETUP;
               wr_data_d = wr_data;
               addr_load = 1'b1;
               addr_next = wr_addr;
            end
         end
         ST_READ: begin
            if (cnt_q == RD_LAST) begin
               sample_en  = 1'b1;
               rd_valid_d = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WR_SETUP: begin
            state_d = ST_WR_PULSE;
            cnt_d   = '0;
         end
         ST_WR_PULSE: begin
            if (cnt_q == WR_LAST) begin
               state_d = ST_WR_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WR_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d   = (state_d != ST_IDLE);
      wr_ack_d = (state_d == ST_WR_HOLD);
      we_n_d   = (state_d != ST_WR_PULSE);
      oe_n_d   = (state_d != ST_READ);
      dq_oe_d  = (state_d == ST_WR_PULSE) || (state_d == ST_WR_HOLD);
   end

   sram_pin_drv #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pin (
      .clk       (CLOCK_50),
      .rst       (RESET),
      .addr_load (addr_load),
      .addr_next (addr_next),
      .we_n_d    (we_n_d),
      .oe_n_d    (oe_n_d),
      .dq_oe_d   (dq_oe_d),
      .wdata     (wr_data_q),
      .sample_en (sample_en),
      .sram_addr (SRAM_ADDR),
      .sram_we_n (SRAM_WE_N),
      .sram_oe_n (SRAM_OE_N),
      .sram_ce_n (SRAM_CE_N),
      .sram_ub_n (SRAM_UB_N),
      .sram_lb_n (SRAM_LB_N),
      .rd_data   (rd_data),
      .sram_dq   (SRAM_DQ)
   );

   assign rd_valid = rd_valid_q;
   assign wr_ack   = wr_ack_q;
   assign busy     = busy_q;

`ifdef SRAM_ARB_STATS_EN
   logic [ADDR_W-1:0] wr_count_q, wr_count_d;
   logic [3:0]        pend_wait_q, pend_wait_d;
   logic [3:0]        fly_wait_q, fly_wait_d;
   logic [3:0]        rd_wait_max_q, rd_wait_max_d;

   // Latency is measured from the newest rd_req, since that is the address actually served.
   always_comb begin
      wr_count_d    = wr_count_q + ADDR_W'(wr_ack_q);
      pend_wait_d   = rd_req ? 4'd1 : sat_inc4(pend_wait_q);
      fly_wait_d    = sat_inc4(fly_wait_q);
      rd_wait_max_d = rd_wait_max_q;
      if (rd_start) begin
         fly_wait_d = rd_req ? 4'd1 : sat_inc4(pend_wait_q);
      end
      if (rd_valid_q && (fly_wait_q > rd_wait_max_q)) begin
         rd_wait_max_d = fly_wait_q;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         wr_count_q    <= '0;
         pend_wait_q   <= '0;
         fly_wait_q    <= '0;
         rd_wait_max_q <= '0;
      end else begin
         wr_count_q    <= wr_count_d;
         pend_wait_q   <= pend_wait_d;
         fly_wait_q    <= fly_wait_d;
         rd_wait_max_q <= rd_wait_max_d;
      end
   end

   assign wr_count    = wr_count_q;
   assign rd_wait_max = rd_wait_max_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, a memory/latency
// reference model, directed scenarios and randomized write/read mixes.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   localparam int AW   = SRAM_ADDR_W;
   localparam int DW   = SRAM_DATA_W;
   localparam int RDC  = DEF_RD_CYCLES;
   localparam int WRC  = DEF_WR_CYCLES;
   localparam int NREL = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          busy;
   logic [AW-1:0] sram_addr;
   wire  [DW-1:0] sram_dq;
   logic          sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_ARB_STATS_EN
   logic [AW-1:0] wr_count;
   logic [3:0]    rd_wait_max;
`endif

   logic [DW-1:0] sram_mem [0:(1<<AW)-1];
   logic [DW-1:0] model_mem [int];
   int tests_run = 0;
   int tests_failed = 0;
   int contention = 0;
   int wr_total = 0;
   int max_lat = 0;
   int aborted_acks;
   logic [AW-1:0] prev_addr, wa, ra;

   always #5 clk = ~clk;

   sram_arbiter dut (
      .CLOCK_50  (clk),
      .RESET     (rst),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .busy      (busy),
      .SRAM_ADDR (sram_addr),
      .SRAM_DQ   (sram_dq),
      .SRAM_WE_N (sram_we_n),
      .SRAM_OE_N (sram_oe_n),
      .SRAM_CE_N (sram_ce_n),
      .SRAM_UB_N (sram_ub_n),
      .SRAM_LB_N (sram_lb_n)
`ifdef SRAM_ARB_STATS_EN
      ,
      .wr_count    (wr_count),
      .rd_wait_max (rd_wait_max)
`endif
   );

   // Asynchronous SRAM: drives DQ while OE_N is low, stores on cycles with WE_N low.
   assign sram_dq = (!sram_oe_n && !sram_ce_n && sram_we_n) ? sram_mem[sram_addr] : {DW{1'bz}};

   always @(posedge clk) begin
      if (!sram_we_n && !sram_ce_n) sram_mem[sram_addr] = sram_dq;
   end

   always @(negedge clk) begin
      if (dut.u_pin.dq_oe_q && !sram_oe_n) contention++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
      return model_mem.exists(int'(a)) ? model_mem[int'(a)] : '0;
   endfunction

   // One write and/or up to two reads issued at cycle offsets k/k2 from a common start.
   // Expected timing: a lone read returns RD+1 cycles later; a read that loses to a write
   // waits until the first idle cycle after wr_ack; a read that collides with a fresh write wins.
   task automatic applyStimulus(input bit do_wr, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                                input bit do_rd, input logic [AW-1:0] raddr, input int k,
                                input logic [AW-1:0] raddr2, input int k2, input string name);
      int acc, ack_exp, valid_exp, r, lat;
      int ack_rel, valid_rel, ack_cnt, valid_cnt, we_low;
      logic [AW-1:0] eff_addr;
      logic [DW-1:0] exp_data, got_data;
      logic busy1;
      bit acked;

      acc      = (do_rd && k == 0) ? RDC + 1 : 0;
      ack_exp  = acc + WRC + 2;
      r        = (k2 >= 0) ? k2 : k;
      eff_addr = (k2 >= 0) ? raddr2 : raddr;
      if (do_rd && k == 0)  valid_exp = RDC + 1;
      else if (do_wr)       valid_exp = ((r > ack_exp + 1) ? r : ack_exp + 1) + RDC + 1;
      else                  valid_exp = r + RDC + 1;
      exp_data = (do_wr && valid_exp > ack_exp && eff_addr == waddr) ? wdata : modelRead(eff_addr);

      ack_rel = -1; valid_rel = -1; ack_cnt = 0; valid_cnt = 0; we_low = 0;
      got_data = '0; busy1 = 1'b0; acked = 1'b0;
      wr_addr = waddr;
      wr_data = wdata;
      for (int rel = 0; rel < NREL; rel++) begin
         if (wr_ack) begin
            ack_cnt++;
            if (ack_rel < 0) ack_rel = rel;
            acked = 1'b1;
         end
         if (rd_valid) begin
            valid_cnt++;
            valid_rel = rel;
            got_data  = rd_data;
         end
         if (!sram_we_n) we_low++;
         if (rel == 1) busy1 = busy;
         wr_req  = do_wr && !acked;
         rd_req  = do_rd && (rel == k || rel == k2);
         rd_addr = (rel == k2) ? raddr2 : raddr;
         @(negedge clk);
      end
      wr_req = 1'b0;
      rd_req = 1'b0;

      checkOutput($sformatf("%s busy_start", name), busy1, do_wr || (do_rd && k == 0));
      checkOutput($sformatf("%s busy_end", name), busy, 1'b0);
      if (do_wr) begin
         checkOutput($sformatf("%s ack_cycle", name), ack_rel, ack_exp);
         checkOutput($sformatf("%s ack_count", name), ack_cnt, 1);
         checkOutput($sformatf("%s we_low_cycles", name), we_low, WRC);
         model_mem[int'(waddr)] = wdata;
         wr_total++;
      end
      if (do_rd) begin
         checkOutput($sformatf("%s valid_cycle", name), valid_rel, valid_exp);
         checkOutput($sformatf("%s valid_count", name), valid_cnt, 1);
         checkOutput($sformatf("%s rd_data", name), got_data, exp_data);
         lat = valid_exp - r;
         if (lat > 15) lat = 15;
         if (lat > max_lat) max_lat = lat;
      end
   endtask

   task automatic checkStats(input string name);
`ifdef SRAM_ARB_STATS_EN
      checkOutput($sformatf("%s wr_count", name), wr_count, AW'(wr_total));
      checkOutput($sformatf("%s rd_wait_max", name), rd_wait_max, 4'(max_lat));
`else
      checkOutput($sformatf("%s ce_n", name), sram_ce_n, 1'b0);
`endif
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      checkOutput("idle we_n", sram_we_n, 1'b1);
      checkOutput("idle oe_n", sram_oe_n, 1'b1);
      checkOutput("idle ce_n", sram_ce_n, 1'b0);
      checkOutput("idle ub_lb", {sram_ub_n, sram_lb_n}, 2'b00);
      checkOutput("idle dq_drive", dut.u_pin.dq_oe_q, 1'b0);
      checkOutput("idle rd_valid", rd_valid, 1'b0);
      checkOutput("idle busy", busy, 1'b0);
      checkOutput("idle addr", sram_addr, '0);
      checkOutput("idle rd_data", rd_data, '0);

      applyStimulus(1, 18'h00A14, 16'h0001, 0, '0, -1, '0, -1, "t2_write");
      applyStimulus(0, '0, '0, 1, 18'h00A14, 0, '0, -1, "t2_read");
      applyStimulus(1, 18'h01234, 16'hCAFE, 1, 18'h00A14, 0, '0, -1, "t3_collide");
      applyStimulus(1, 18'h02000, 16'h7777, 1, 18'h01234, 2, '0, -1, "t4_rd_in_wr");
      applyStimulus(1, 18'h00010, 16'h1111, 0, '0, -1, '0, -1, "t5_pre1");
      applyStimulus(1, 18'h00020, 16'h2222, 0, '0, -1, '0, -1, "t5_pre2");
      applyStimulus(1, 18'h00B00, 16'h5A5A, 1, 18'h00010, 2, 18'h00020, 4, "t5_double");
      applyStimulus(0, '0, '0, 1, 18'h3FFFF, 3, '0, -1, "edge_top_addr");

      prev_addr = 18'h00020;
      for (int i = 0; i < 40; i++) begin
         wa = AW'($urandom_range(0, (1 << AW) - 1));
         if (wa == prev_addr) wa = wa ^ 18'h1;
         ra = ($urandom_range(0, 3) == 0) ? wa : prev_addr;
         applyStimulus(1, wa, DW'($urandom), ($urandom_range(0, 4) != 0), ra,
                       int'($urandom_range(0, 7)), '0, -1, $sformatf("rnd%0d", i));
         prev_addr = wa;
      end
      checkStats("after_random");
      checkOutput("bus_contention", contention, 0);

      // Abort a write in the middle of its WE_N pulse.
      wr_addr = 18'h00C00; wr_data = 16'hBEEF; wr_req = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("t6 we_low_before_reset", sram_we_n, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6 we_n", sram_we_n, 1'b1);
      checkOutput("t6 oe_n", sram_oe_n, 1'b1);
      checkOutput("t6 dq_drive", dut.u_pin.dq_oe_q, 1'b0);
      checkOutput("t6 busy", busy, 1'b0);
      rst = 1'b0; wr_req = 1'b0;
      aborted_acks = 0;
      for (int i = 0; i < 10; i++) begin
         if (wr_ack) aborted_acks++;
         @(negedge clk);
      end
      checkOutput("t6 no_ack", aborted_acks, 0);
      wr_total = 0;
      max_lat = 0;
      checkStats("after_reset");

      applyStimulus(1, 18'h00C00, 16'hBEEF, 1, 18'h00C00, 7, '0, -1, "t6_rerequest");
      checkStats("final");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
